// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_pkg
// Description : Shared operation encodings and the signed-divide helper for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    // Returns {remainder, quotient}; the remainder takes the dividend's sign.
    function automatic logic [63:0] signed_divide(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        mag_a = a[31] ? (~a + 32'd1) : a;
        mag_b = b[31] ? (~b + 32'd1) : b;
        quo   = mag_a / mag_b;
        rem   = mag_a % mag_b;
        if (a[31] ^ b[31]) quo = ~quo + 32'd1;
        if (a[31])         rem = ~rem + 32'd1;
        return {rem, quo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Request/result bundle between the E stage and md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;
    import md_unit_pkg::*;

    logic               Start;
    logic [MD_OP_W-1:0] MDOp;
    logic [31:0]        A;
    logic [31:0]        B;
    logic               Busy;
    logic [31:0]        HI;
    logic [31:0]        LO;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    md_unit_if.slave   md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_we;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [63:0]   div_s;
    logic [63:0]   div_u;
    logic          b_zero;

    assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    assign prod_u = {32'd0, md.A} * {32'd0, md.B};
    assign b_zero = (md.B == 32'd0);
    // Divider inputs are forced non-zero when B=0; the result is discarded anyway.
    assign div_s  = signed_divide(md.A, b_zero ? 32'd1 : md.B);
    assign div_u  = {md.A % (b_zero ? 32'd1 : md.B), md.A / (b_zero ? 32'd1 : md.B)};

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else if (count != '0) begin
            count <= count - CW'(1);
            if (count == CW'(1) && pend_we) begin
                hi      <= pend_hi;
                lo      <= pend_lo;
                pend_we <= 1'b0;
            end
        end else if (md.Start) begin
            case (md.MDOp)
                MD_MULT: begin
                    {pend_hi, pend_lo} <= prod_s;
                    pend_we            <= 1'b1;
                    count              <= CW'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    {pend_hi, pend_lo} <= prod_u;
                    pend_we            <= 1'b1;
                    count              <= CW'(MULT_CYCLES);
                end
                MD_DIV: begin
                    {pend_hi, pend_lo} <= div_s;
                    pend_we            <= !b_zero;
                    count              <= CW'(DIV_CYCLES);
                end
                MD_DIVU: begin
                    {pend_hi, pend_lo} <= div_u;
                    pend_we            <= !b_zero;
                    count              <= CW'(DIV_CYCLES);
                end
                MD_MTHI: hi <= md.A;
                MD_MTLO: lo <= md.A;
                default: ;
            endcase
        end
    end

    assign md.Busy = (count != '0);
    assign md.HI   = hi;
    assign md.LO   = lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed and randomized checks of md_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   total;
    int   pass_cnt;
    int   fail_cnt;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint          p;
        longint unsigned u;
        longint          q;
        longint          r;
        case (op)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
            3'd2: begin
                if (b == 0) return {hi, lo};
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) - q * longint'($signed(b));
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {hi, lo};
                return {a % b, a / b};
            end
            3'd4:    return {a, lo};
            3'd5:    return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int busy_len(input logic [2:0] op);
        if (op <= 3'd1) return MULT_N;
        if (op <= 3'd3) return DIV_N;
        return 0;
    endfunction

    // Issues one op in the current cycle and returns in the first cycle after it completes.
    // junk: 0 = quiet while busy, 1 = random Start/MDOp while busy, 2 = MTHI 0x12345678 while busy.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int junk);
        logic [63:0] exp;
        int          n;
        exp = ref_md(op, a, b, m_hi, m_lo);
        n   = busy_len(op);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        for (int i = 1; i <= n; i++) begin
            check("busy_high", {31'd0, bus.Busy}, 32'd1);
            check("hi_hold", bus.HI, m_hi);
            check("lo_hold", bus.LO, m_lo);
            if (junk == 1) begin
                bus.Start = 1'($urandom_range(0, 1));
                bus.MDOp  = 3'($urandom_range(0, 7));
                bus.A     = $urandom;
                bus.B     = $urandom;
            end else if (junk == 2 && i == 1) begin
                bus.Start = 1'b1; bus.MDOp = 3'd4; bus.A = 32'h12345678;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.Start = 1'b0;
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check("busy_low", {31'd0, bus.Busy}, 32'd0);
        check("hi_result", bus.HI, m_hi);
        check("lo_result", bus.LO, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        total = 0; pass_cnt = 0; fail_cnt = 0;
        m_hi = '0; m_lo = '0;

        // Reset with a request pending: reset wins.
        reset = 1'b1;
        bus.Start = 1'b1; bus.MDOp = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; bus.Start = 1'b0;
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);

        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 0);
        check("mult_hi_const", bus.HI, 32'hFFFFFFFF);
        check("mult_lo_const", bus.LO, 32'hFFFFFFFA);

        // Issued in the first idle cycle: back-to-back acceptance.
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("multu_hi_const", bus.HI, 32'hFFFFFFFE);
        check("multu_lo_const", bus.LO, 32'h00000001);

        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
        check("div_hi_const", bus.HI, 32'hFFFFFFFF);
        check("div_lo_const", bus.LO, 32'hFFFFFFFD);

        do_op(3'd3, 32'd7, 32'd0, 0);
        check("divu0_hi_const", bus.HI, 32'hFFFFFFFF);
        check("divu0_lo_const", bus.LO, 32'hFFFFFFFD);

        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        check("divovf_hi_const", bus.HI, 32'd0);
        check("divovf_lo_const", bus.LO, 32'h80000000);

        // MTHI during busy is dropped; reissued once idle it lands without Busy.
        do_op(3'd0, 32'd6, 32'd7, 2);
        check("mthi_ignored", bus.HI, 32'd0);
        do_op(3'd4, 32'h12345678, 32'd0, 0);
        check("mthi_const", bus.HI, 32'h12345678);
        @(posedge clk); #1;
        check("mthi_busy_next", {31'd0, bus.Busy}, 32'd0);
        do_op(3'd5, 32'hCAFEF00D, 32'd0, 0);
        do_op(3'd6, 32'h11111111, 32'd5, 0);
        do_op(3'd7, 32'h22222222, 32'd0, 0);

        // Reset in busy cycle 3 of a DIV.
        bus.Start = 1'b1; bus.MDOp = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        check("midrst_hi", bus.HI, 32'd0);
        check("midrst_lo", bus.LO, 32'd0);
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        check("midrst_hi_late", bus.HI, 32'd0);
        check("midrst_lo_late", bus.LO, 32'd0);

        // Randomized ops, with random traffic while busy.
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            do_op(op, a, b, int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL declare parameter MULT_CYCLES, default 5, busy duration of mult/multu.
REQ-002 SHALL declare parameter DIV_CYCLES, default 10, busy duration of div/divu.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1, E-stage request to execute MDOp this cycle.
REQ-006 SHALL have port MDOp, input, 3, operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A, input, 32, rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-008 SHALL have port B, input, 32, rt operand (divisor / multiplier).
REQ-009 SHALL have port Busy, output, 1, high while a mult/div is in flight.
REQ-010 SHALL have port HI, output, 32, architectural HI register.
REQ-011 SHALL have port LO, output, 32, architectural LO register.

Function
REQ-012 SHALL accept a mult/div only when Start=1 and Busy=0; operands and op are latched at that edge.
REQ-013 SHALL ignore Start entirely, for any MDOp, while Busy=1; the in-flight operation is unaffected.
REQ-014 SHALL, for an op accepted at the edge ending cycle T, hold Busy=1 in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES), with Busy=0 in cycle T+N+1.
REQ-015 SHALL update HI/LO at the edge ending cycle T+N; HI/LO keep their old values during cycles T+1..T+N.
REQ-016 SHALL be implemented as a down-counter loaded with N at acceptance; Busy = (counter != 0).
REQ-017 SHALL compute MULT as a 64-bit signed product {HI,LO}.
REQ-018 SHALL compute MULTU as a 64-bit unsigned product {HI,LO}.
REQ-019 SHALL compute DIV as signed: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
REQ-020 SHALL compute DIVU as unsigned: LO = quotient, HI = remainder.
REQ-021 SHALL leave HI and LO unchanged on DIV/DIVU with B=0, while still asserting Busy for DIV_CYCLES.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-023 SHALL, on MTHI/MTLO with Start=1 and Busy=0, write A into HI/LO at that edge without asserting Busy.
REQ-024 SHALL treat Start=1 with an undefined MDOp encoding as a no-op.
REQ-025 SHALL make a new op issued in cycle T+N+1 (first cycle with Busy=0) legal; it is accepted normally.
REQ-026 SHALL drive HI/LO directly from registers, with no combinational path from inputs.
REQ-027 SHALL leave stalling to the hazard unit, which stalls D when an md instruction (including mfhi/mflo) meets (Start | Busy).

Reset
REQ-028 SHALL, on reset=1 at a rising edge, set HI=0, LO=0, counter=0 and Busy=0.
REQ-029 SHALL give reset priority over Start.
REQ-030 SHALL, on reset mid-operation, discard the pending result; HI/LO are never written by it.

Structure
REQ-031 SHALL place the MDOp encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) in shared const.v, next to the ALUOp/EXTOp encodings.
REQ-032 SHALL have EController drive Start and MDOp from opcode/funct; md_unit does not decode instructions.
REQ-033 SHALL be a single module with no sub-module; the result is computed at acceptance into pending registers and committed when the counter reaches 1.

Verification
REQ-034 SHALL cover MULT A=0xFFFFFFFE, B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-035 SHALL cover MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
REQ-036 SHALL cover DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI/LO unchanged.
REQ-037 SHALL cover MTHI A=0x12345678 issued during Busy -> ignored; reissued after Busy falls -> HI=0x12345678 next cycle with Busy never asserted.
REQ-038 SHALL cover reset asserted in busy cycle 3 of a DIV -> next cycle Busy=0, HI=LO=0, and no later HI/LO change.
REQ-039 SHALL cover a back-to-back MULT issued in the first Busy=0 cycle -> accepted, Busy high 5 more cycles, and the first result visible in between.
